// File: rtl/spi_slave_fsm.sv
// Control FSM for the SmolBoi SPI slave: sequences the header/data phases of a
// transaction and drives the shift register, address register, data memory and
// MISO buffer enables.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   GET    | shifting in the WIDTH-bit header on SCLK rising edges
//   GOT    | header complete; latch address, branch on the R/W bit
//   READ1  | wait one clk for data memory read latency
//   READ2  | parallel-load the memory word into the shift register
//   READ3  | drive MISO; shift out WIDTH bits on SCLK falling edges
//   WRITE1 | shifting in the WIDTH-bit data word on SCLK rising edges
//   WRITE2 | write the shifted-in word to the latched address
//   DONE   | transaction finished; idle until CS deasserts
module spi_slave_fsm #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       sclk_posedge,
    input  logic       sclk_negedge,
    input  logic       rw_bit,
    output logic       sr_we,
    output logic       addr_we,
    output logic       dm_we,
    output logic       miso_buff,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        GET    = 3'd0,
        GOT    = 3'd1,
        READ1  = 3'd2,
        READ2  = 3'd3,
        READ3  = 3'd4,
        WRITE1 = 3'd5,
        WRITE2 = 3'd6,
        DONE   = 3'd7
    } state_t;

    // Terminal count: the strobe that arrives while cnt holds WIDTH-1 is the
    // WIDTH-th one, so the counter never has to reach WIDTH and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and bit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; CS deassertion overrides every other event.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cs) begin
            state_d = GET;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                GET: begin
                    if (sclk_posedge) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = GOT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                GOT:    state_d = rw_bit ? READ1 : WRITE1;
                READ1:  state_d = READ2;
                READ2:  state_d = READ3;
                READ3: begin
                    if (sclk_negedge) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                WRITE1: begin
                    if (sclk_posedge) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = WRITE2;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                WRITE2: state_d = DONE;
                DONE:   state_d = DONE;
                default: begin
                    state_d = GET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Moore enable decode straight from the state register, one-hot by state.
    always_comb begin
        sr_we     = 1'b0;
        addr_we   = 1'b0;
        dm_we     = 1'b0;
        miso_buff = 1'b0;
        case (state_q)
            GOT:     addr_we   = 1'b1;
            READ2:   sr_we     = 1'b1;
            READ3:   miso_buff = 1'b1;
            WRITE2:  dm_we     = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
